// File: rtl/router_pkg.sv
// router_pkg: shared FSM states and constants for the 1x3 router controller
package router_pkg;
  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;
  localparam logic [1:0] ADDR_INVALID = 2'd3;
  localparam int NUM_PORTS = 3;
endpackage

// File: rtl/router_timeout.sv
// router_timeout: per-port read timeout (vld, read_enb in; one-cycle soft_reset pulse out)
module router_timeout #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);
  logic [7:0] cnt_q, cnt_d;
  logic       sr_q, sr_d;
  always_comb begin
    sr_d  = vld && !read_enb && cnt_q == 8'(TIMEOUT - 1);
    cnt_d = (!vld || read_enb || sr_d) ? '0 : cnt_q + 8'd1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      sr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
  assign soft_reset = sr_q;
endmodule

// File: rtl/router_ctrl.sv
// router_ctrl: 1x3 router controller (source pkt_valid/data_in/busy/error; FIFO write_enb/wr_data/lfd; per-port vld_out/soft_reset)
module router_ctrl
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic                 busy,
  output logic                 error,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 lfd,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset
);
  localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};
  state_t                 state_q, state_d;
  logic [1:0]             addr_q, addr_d;
  logic [DATA_W-1:0]      hdr_q, hdr_d, hold_q, hold_d, par_q, par_d, pbyte_q, pbyte_d, wd_q, wd_d;
  logic [NUM_PORTS-1:0]   we_q, we_d;
  logic                   err_q, err_d, lfd_q, lfd_d, drop_q, drop_d;
  logic [NUM_PORTS-1:0]   oh, din_oh;
  logic                   full_a, empty_a, empty_in;
  assign oh       = ONE << addr_q;
  assign din_oh   = ONE << data_in[1:0];
  assign full_a   = |(fifo_full & oh);
  assign empty_a  = |(fifo_empty & oh);
  assign empty_in = |(fifo_empty & din_oh);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hdr_d   = hdr_q;
    hold_d  = hold_q;
    par_d   = par_q;
    pbyte_d = pbyte_q;
    err_d   = err_q;
    wd_d    = wd_q;
    we_d    = '0;
    lfd_d   = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      DECODE_ADDRESS: begin
        // drop_q swallows the rest of an invalid packet so its payload is never decoded as a header
        if (!pkt_valid) drop_d = 1'b0;
        else if (!drop_q) begin
          if (data_in[1:0] == ADDR_INVALID) drop_d = 1'b1;
          else begin
            addr_d  = data_in[1:0];
            hdr_d   = data_in;
            state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
      end
      WAIT_TILL_EMPTY: state_d = empty_a ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA: begin
        we_d    = oh;
        wd_d    = hdr_q;
        lfd_d   = 1'b1;
        par_d   = hdr_q;
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (pkt_valid && !full_a) begin
          we_d  = oh;
          wd_d  = data_in;
          par_d = par_q ^ data_in;
        end else if (pkt_valid) begin
          hold_d  = data_in;
          state_d = FIFO_FULL_STATE;
        end else begin
          pbyte_d = data_in;
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: state_d = full_a ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        we_d    = oh;
        wd_d    = hold_q;
        par_d   = par_q ^ hold_q;
        state_d = LOAD_DATA;
      end
      LOAD_PARITY: begin
        if (!full_a) begin
          we_d    = oh;
          wd_d    = pbyte_q;
          state_d = CHECK_PARITY_ERROR;
        end
      end
      CHECK_PARITY_ERROR: begin
        err_d   = par_q != pbyte_q;
        state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
      hdr_q   <= '0;
      hold_q  <= '0;
      par_q   <= '0;
      pbyte_q <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      we_q    <= '0;
      lfd_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      hold_q  <= hold_d;
      par_q   <= par_d;
      pbyte_q <= pbyte_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      lfd_q   <= lfd_d;
      drop_q  <= drop_d;
    end
  end
  assign busy      = !(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);
  assign error     = err_q;
  assign write_enb = we_q;
  assign wr_data   = wd_q;
  assign lfd       = lfd_q;
  assign vld_out   = ~fifo_empty;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_to
    router_timeout #(.TIMEOUT(TIMEOUT)) u_to (
      .clock     (clock),
      .reset     (reset),
      .vld       (vld_out[i]),
      .read_enb  (read_enb[i]),
      .soft_reset(soft_reset[i])
    );
  end
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: scoreboard bench for router_ctrl packet writes, parity, back-pressure and timeouts
module tb_router_ctrl;
  logic       clock = 1'b0, reset = 1'b1, pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] fifo_full = 3'b000, fifo_empty = 3'b111, read_enb = 3'b000;
  logic       busy, error, lfd;
  logic [2:0] write_enb, vld_out, soft_reset;
  logic [7:0] wr_data;
  int         checks = 0, errors = 0;
  bit         mon_en = 1'b0;
  typedef struct packed {logic [2:0] we; logic [7:0] d; logic l;} wr_t;
  wr_t        sb[$];
  wr_t        exp_w;
  logic [7:0] pl[$];
  int         bc;

  always #5 clock = ~clock;

  router_ctrl #(.DATA_W(8), .TIMEOUT(30)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .busy(busy), .error(error), .write_enb(write_enb), .wr_data(wr_data),
    .lfd(lfd), .vld_out(vld_out), .soft_reset(soft_reset)
  );

  always @(negedge clock) begin
    if (mon_en && write_enb !== 3'b000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: write_enb=%b wr_data=%h lfd=%b, required no write", write_enb, wr_data, lfd);
      end else begin
        exp_w = sb.pop_front();
        if ({write_enb, wr_data, lfd} !== exp_w) begin
          errors++;
          $display("FAIL write: got we=%b data=%h lfd=%b, required we=%b data=%h lfd=%b",
                   write_enb, wr_data, lfd, exp_w.we, exp_w.d, exp_w.l);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] xor_all(input logic [7:0] hdr);
    logic [7:0] x;
    x = hdr;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par, input int full_at,
                             input int wait_n, output int busy_cnt);
    logic [7:0] b[$];
    logic [1:0] p;
    int t;
    p = hdr[1:0];
    b.push_back(hdr);
    foreach (pl[i]) b.push_back(pl[i]);
    b.push_back(par);
    busy_cnt = 0;
    for (int k = 0; k < b.size(); k++) begin
      @(negedge clock);
      data_in   = b[k];
      pkt_valid = (k < b.size() - 1);
      if (k == full_at) fifo_full[p] = 1'b1;
      t = 0;
      while (busy === 1'b1 && t < 64) begin
        busy_cnt++;
        t++;
        @(negedge clock);
      end
      if (t == 64) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %0d busy=%b, required 0", k, busy);
      end
      if (p != 2'd3) sb.push_back({3'b001 << p, b[k], k == 0});
      @(posedge clock);
      if (k == 0 && wait_n > 0) begin
        for (int w = 0; w < wait_n; w++) begin
          @(negedge clock);
          checks++;
          if (busy !== 1'b1 || write_enb !== 3'b000) begin
            errors++;
            $display("FAIL wait_hold: busy=%b write_enb=%b, required busy=1 write_enb=000", busy, write_enb);
          end
        end
        fifo_empty[p] = 1'b1;
      end
      if (k == full_at) begin
        for (int w = 0; w < 3; w++) begin
          @(negedge clock);
          checks++;
          if (busy !== 1'b1 || write_enb !== 3'b000) begin
            errors++;
            $display("FAIL full_hold: busy=%b write_enb=%b, required busy=1 write_enb=000", busy, write_enb);
          end
        end
        fifo_full[p] = 1'b0;
      end
    end
    @(negedge clock);
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    t = 0;
    while (busy === 1'b1 && t < 64) begin
      busy_cnt++;
      t++;
      @(negedge clock);
    end
    if (t == 64) begin
      checks++;
      errors++;
      $display("FAIL return_timeout: busy=%b, required 0", busy);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_error(input string name, input logic exp);
    checks++;
    if (error !== exp) begin
      errors++;
      $display("FAIL %s: error=%b, required %b", name, error, exp);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, error, write_enb, wr_data, lfd, soft_reset, vld_out} !== {1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 3'b000, 3'b000}) begin
      errors++;
      $display("FAIL reset_state: busy=%b error=%b we=%b data=%h lfd=%b sr=%b vld=%b, required all zero",
               busy, error, write_enb, wr_data, lfd, soft_reset, vld_out);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_good_packet;
    pl = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0D, xor_all(8'h0D), -1, 0, bc);
    checks++;
    if (bc != 3) begin
      errors++;
      $display("FAIL good_busy_cycles: got %0d, required 3", bc);
    end
    check_error("good_error", 1'b0);
  endtask

  task automatic test_bad_parity;
    pl = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0D, 8'hFF, -1, 0, bc);
    check_error("bad_parity_error", 1'b1);
    pl = '{8'h44};
    send_packet(8'h0D, xor_all(8'h0D), -1, 0, bc);
    check_error("error_cleared", 1'b0);
  endtask

  task automatic test_fifo_full;
    pl = '{8'h44, 8'h55, 8'h66};
    send_packet(8'h0C, xor_all(8'h0C), 2, 0, bc);
    check_error("full_error", 1'b0);
  endtask

  task automatic test_wait_empty;
    fifo_empty = 3'b011;
    pl = '{8'h5A, 8'hA5};
    send_packet(8'h0A, xor_all(8'h0A), -1, 4, bc);
    check_error("wait_error", 1'b0);
  endtask

  task automatic test_invalid_addr;
    pl = '{8'h01, 8'h02};
    send_packet(8'h03, 8'h55, -1, 0, bc);
    check_error("invalid_error", 1'b0);
    pl = '{8'h77, 8'h88};
    send_packet(8'h06, xor_all(8'h06), -1, 0, bc);
    check_error("after_invalid_error", 1'b0);
  endtask

  task automatic test_timeout;
    @(negedge clock);
    fifo_empty = 3'b110;
    read_enb   = 3'b000;
    #1;
    checks++;
    if (vld_out !== 3'b001) begin
      errors++;
      $display("FAIL vld_out: got %b, required 001", vld_out);
    end
    for (int k = 1; k <= 31; k++) begin
      @(negedge clock);
      checks++;
      if (soft_reset !== {2'b00, k == 30}) begin
        errors++;
        $display("FAIL timeout_pulse: cycle %0d soft_reset=%b, required %b", k, soft_reset, {2'b00, k == 30});
      end
    end
    fifo_empty = 3'b111;
    @(negedge clock);
    fifo_empty = 3'b110;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clock);
      checks++;
      if (soft_reset !== 3'b000) begin
        errors++;
        $display("FAIL read_wins: cycle %0d soft_reset=%b, required 000", k, soft_reset);
      end
      if (k == 29) read_enb = 3'b001;
      if (k == 30) read_enb = 3'b000;
    end
    fifo_empty = 3'b111;
  endtask

  task automatic test_reset_mid;
    pl = '{8'h11};
    send_packet(8'h0D, 8'h00, -1, 0, bc);
    check_error("pre_reset_error", 1'b1);
    mon_en = 1'b0;
    @(negedge clock);
    data_in   = 8'h01;
    pkt_valid = 1'b1;
    @(negedge clock);
    data_in = 8'hAB;
    repeat (2) @(negedge clock);
    data_in = 8'hCD;
    reset   = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, error, write_enb, wr_data, lfd, soft_reset} !== {1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset: busy=%b error=%b we=%b data=%h lfd=%b sr=%b, required all zero",
               busy, error, write_enb, wr_data, lfd, soft_reset);
    end
    reset     = 1'b0;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    sb.delete();
    mon_en = 1'b1;
    pl = '{8'h21, 8'h42};
    send_packet(8'h0D, xor_all(8'h0D), -1, 0, bc);
    checks++;
    if (bc != 3) begin
      errors++;
      $display("FAIL post_reset_busy: got %0d, required 3", bc);
    end
    check_error("post_reset_error", 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full();
    test_wait_empty();
    test_invalid_addr();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
